// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and
// default values for the reset PC and the halt word.
package fetch_pkg;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;

  // A byte address is word aligned when its two low bits are zero
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Owns the PC, addresses the combinational ROM,
// and registers each fetched word into a one-entry output stage for decode.
// Redirects load a new PC (or fault on a misaligned target); fetch stops on
// the halt word or when the PC runs past the end of the ROM.
//
// Output handshake: a beat (instr_out, pc_out) is offered while instr_valid
// is high and is consumed on a rising edge where instr_valid and instr_ready
// are both high. Once raised, instr_valid stays high and the beat stays stable
// until it is consumed, except that a redirect, restart or reset discards it.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W     = 5,
  parameter int                PC_W       = 32,
  parameter logic [PC_W-1:0]   RESET_PC   = PC_W'(RESET_PC_DEFAULT),
  parameter logic [31:0]       HALT_INSTR = HALT_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  output logic [31:0]       instr_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              restart,
  output logic              halted,
  output logic              fault
);

  logic [1:0]      state;
  logic [PC_W-1:0] pc;

  logic slot_open;
  logic out_of_range;
  logic halt_word;
  logic target_ok;

  // Word address into the ROM and the fetch-slot / stop conditions
  assign rom_addr     = pc[ADDR_W+1:2];
  assign slot_open    = !instr_valid || instr_ready;
  assign out_of_range = |pc[PC_W-1:ADDR_W+2];
  assign halt_word    = (rom_instr == HALT_INSTR);
  assign target_ok    = is_word_aligned(redirect_pc[1:0]);

  // Sequencer state, PC and registered output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // One quiet cycle before fetch starts; redirect/restart ignored
          state <= ST_RUN;
        end

        ST_RUN: begin
          if (redirect_valid) begin
            // Flush the output stage whatever decode is doing
            instr_valid <= 1'b0;
            if (target_ok) begin
              pc <= redirect_pc;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (slot_open) begin
            if (out_of_range || halt_word) begin
              // Stop without a beat; PC stays on the stopping address
              state       <= ST_HALT;
              halted      <= 1'b1;
              instr_valid <= 1'b0;
            end else begin
              instr_out   <= rom_instr;
              pc_out      <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + PC_W'(4);
            end
          end
        end

        ST_HALT: begin
          if (restart) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            halted      <= 1'b0;
            instr_valid <= 1'b0;
          end else if (redirect_valid) begin
            halted      <= 1'b0;
            instr_valid <= 1'b0;
            if (target_ok) begin
              state <= ST_RUN;
              pc    <= redirect_pc;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (instr_valid && instr_ready) begin
            // A beat left over from before the halt may still drain
            instr_valid <= 1'b0;
          end
        end

        ST_FAULT: begin
          // Only restart (or rst) leaves FAULT
          if (restart) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            instr_valid <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a ROM image in an array, a cycle-level reference
// model of the fetch rules compared against the DUT every falling edge, and
// directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        restart = 1'b0;
  logic        halted;
  logic        fault;

  logic [31:0] rom [0:31];

  int checks = 0;
  int errors = 0;

  // Accepted beats seen on the DUT output, and expected PCs for scenario 1
  logic [31:0] got_pc_q[$];
  logic [31:0] got_instr_q[$];
  logic [31:0] exp_q[$];

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .restart(restart), .halted(halted), .fault(fault)
  );

  // Clock / ROM
  always #5 clk = ~clk;
  assign rom_instr = rom[rom_addr];

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = (i >= 11) ? HALT_W : 32'h0;
    rom[0]  = 32'h0080_0293;
    rom[2]  = 32'h0062_a023;
    rom[5]  = 32'h03c3_84b3;
    rom[10] = 32'h0122_a023;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: modes as plain ints, PC as byte arithmetic
  int          m_mode = 0;   // 0 idle, 1 run, 2 halt, 3 fault
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcout = 32'h0;

  function automatic bit stops_at(input logic [31:0] pc);
    if (pc >= 32'd128) return 1'b1;
    return rom[pc / 4] == HALT_W;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_pcout = 32'h0;
  endtask

  task automatic model_redirect(input logic [31:0] tgt);
    m_valid = 1'b0;
    if (tgt % 4 != 0) m_mode = 3;
    else begin
      m_pc = tgt;
      m_mode = 1;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      case (m_mode)
        0: m_mode = 1;
        1: begin
          if (redirect_valid) model_redirect(redirect_pc);
          else if (!m_valid || instr_ready) begin
            if (stops_at(m_pc)) begin
              m_mode = 2;
              m_valid = 1'b0;
            end else begin
              m_instr = rom[m_pc / 4];
              m_pcout = m_pc;
              m_valid = 1'b1;
              m_pc = m_pc + 32'd4;
            end
          end
        end
        2: begin
          if (restart) model_reset();
          else if (redirect_valid) model_redirect(redirect_pc);
          else if (m_valid && instr_ready) m_valid = 1'b0;
        end
        default: if (restart) model_reset();
      endcase
    end
  end

  // Beat monitor
  always @(posedge clk) begin
    if (!rst && instr_valid === 1'b1 && instr_ready) begin
      got_pc_q.push_back(pc_out);
      got_instr_q.push_back(instr_out);
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("valid", {31'b0, instr_valid}, {31'b0, m_valid});
      check("halted", {31'b0, halted}, {31'b0, m_mode == 2});
      check("fault", {31'b0, fault}, {31'b0, m_mode == 3});
      check("rom_addr", {27'b0, rom_addr}, (m_pc / 4) % 32);
      if (m_valid) begin
        check("instr_out", instr_out, m_instr);
        check("pc_out", pc_out, m_pcout);
      end
    end
  end

  // Driver tasks (inputs change on the falling edge)
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic wait_halted(input string name, input int budget);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (halted !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_beat(input string name, input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (instr_valid !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_beat_pc(input string name, input logic [31:0] pc, input int budget);
    int n = 0;
    while (!(instr_valid === 1'b1 && pc_out === pc) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(instr_valid === 1'b1 && pc_out === pc)) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int nbeats;

    // Reset state
    cycles(2);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_rom_addr", {27'b0, rom_addr}, 32'd0);
    rst = 1'b0;

    // 1: straight run to the halt word
    for (int i = 0; i <= 10; i++) exp_q.push_back(32'(i * 4));
    wait_halted("s1", 40);
    cycles(2);
    check("s1_nbeats", 32'(got_pc_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got_pc_q.size()) check("s1_beat_pc", got_pc_q[i], exp_q[i]);
    if (got_instr_q.size() == 11) begin
      check("s1_first_instr", got_instr_q[0], 32'h0080_0293);
      check("s1_last_instr", got_instr_q[10], 32'h0122_a023);
    end
    check("s1_halted", {31'b0, halted}, 32'd1);
    check("s1_valid", {31'b0, instr_valid}, 32'd0);
    check("s1_rom_addr", {27'b0, rom_addr}, 32'd11);
    check("s1_model_pc", m_pc, 32'h2C);

    // 2: back-pressure at pc_out=0x08
    pulse_restart();
    wait_beat_pc("s2", 32'h08, 10);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s2_hold_instr", instr_out, 32'h0062_a023);
      check("s2_hold_pc", pc_out, 32'h08);
      check("s2_hold_addr", {27'b0, rom_addr}, 32'd3);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    check("s2_next_pc", pc_out, 32'h0C);

    // 3: redirect while a beat is stalled
    instr_ready = 1'b0;
    pulse_redirect(32'h14);
    check("s3_flush", {31'b0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    wait_beat("s3", 5);
    check("s3_pc", pc_out, 32'h14);
    check("s3_instr", instr_out, 32'h03c3_84b3);

    // 4: misaligned redirect faults; only restart leaves
    pulse_redirect(32'h06);
    check("s4_fault", {31'b0, fault}, 32'd1);
    nbeats = got_pc_q.size();
    pulse_redirect(32'h10);
    cycles(2);
    check("s4_fault_held", {31'b0, fault}, 32'd1);
    check("s4_no_beats", 32'(got_pc_q.size()), 32'(nbeats));
    pulse_restart();
    check("s4_fault_clear", {31'b0, fault}, 32'd0);
    check("s4_idle_valid", {31'b0, instr_valid}, 32'd0);
    wait_beat("s4", 5);
    check("s4_pc", pc_out, 32'h00);
    check("s4_instr", instr_out, 32'h0080_0293);

    // 5: out-of-range redirect halts, redirect resumes
    pulse_redirect(32'h80);
    nbeats = got_pc_q.size();
    cycles(3);
    check("s5_halted", {31'b0, halted}, 32'd1);
    check("s5_no_beats", 32'(got_pc_q.size()), 32'(nbeats));
    pulse_redirect(32'h00);
    check("s5_left_halt", {31'b0, halted}, 32'd0);
    wait_beat("s5", 5);
    check("s5_pc", pc_out, 32'h00);

    // 6: async reset mid-stream, then restart beats redirect in HALT
    cycles(2);
    #2 rst = 1'b1;
    #1;
    check("s6_rst_valid", {31'b0, instr_valid}, 32'd0);
    check("s6_rst_pc_out", pc_out, 32'd0);
    check("s6_rst_instr", instr_out, 32'd0);
    #1 rst = 1'b0;
    wait_halted("s6", 40);
    restart = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h14;
    @(negedge clk);
    restart = 1'b0;
    redirect_valid = 1'b0;
    check("s6_halt_clear", {31'b0, halted}, 32'd0);
    check("s6_model_pc", m_pc, 32'h00);
    wait_beat("s6", 5);
    check("s6_restart_pc", pc_out, 32'h00);
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #20000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
